// File: rtl/o_ddr_tx_pkg.sv
// Package for the multi-lane DDR burst transmitter.
// Contents:
//   - FSM state encodings (legacy-compatible constants) and the state enum
//   - line symbols driven outside the payload (preamble / idle)
//   - clog2 helper for pointer widths
package o_ddr_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRE   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_POST  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    PRE   = ST_PRE,
    BURST = ST_BURST,
    POST  = ST_POST
  } tx_state_t;

  // Per-lane symbols as {clk-low half, clk-high half}.
  localparam logic [1:0] PREAMBLE_SYM = 2'b01;
  localparam logic [1:0] IDLE_SYM     = 2'b00;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/O_BUFT.sv
// Behavioural model of the O_BUFT tri-state pad buffer.
// Ports:
//   I  in  1  data to the pad
//   T  in  1  output enable, active-high
//   O  out 1  pad; when disabled it shows the weak-keeper level
// Parameter WEAK_KEEPER: "PULLUP" resolves an undriven pad to 1, anything
// else to 0.
module O_BUFT #(
  parameter string WEAK_KEEPER = "NONE"
) (
  input  logic I,
  input  logic T,
  output logic O
);

  assign O = T ? I : (WEAK_KEEPER == "PULLUP");

endmodule

// File: rtl/O_DDR.sv
// Behavioural model of the O_DDR output cell.
// Ports:
//   D  in  2  data; D[0] is presented in the clk-high half, D[1] in the clk-low half
//   R  in  1  asynchronous reset, active-high
//   E  in  1  register enable; low holds the captured pair
//   C  in  1  clock
//   Q  out 1  double-data-rate output
module O_DDR (
  input  logic [1:0] D,
  input  logic       R,
  input  logic       E,
  input  logic       C,
  output logic       Q
);

  logic [1:0] d_q;

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge C or posedge R) begin
    if (R)      d_q <= 2'b00;
    else if (E) d_q <= D;
  end

  assign Q = C ? d_q[0] : d_q[1];

endmodule

// File: rtl/o_ddr_tx_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH, with registered full/empty flags.
// Ports:
//   clk_buf_i, reset_n_buf   clock, asynchronous active-low reset
//   push, wr_data            write request (ignored while full)
//   pop                      read request (ignored while empty)
//   rd_data                  head-of-queue word (valid while !empty)
//   full, empty              registered status flags
module o_ddr_tx_fifo
  import o_ddr_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_buf_i,
  input  logic             reset_n_buf,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem [DEPTH];

  // Flags are the pre-edge view, so a push while full is refused even if a
  // pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk_buf_i or negedge reset_n_buf) begin
    if (!reset_n_buf) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt == {~rd_ptr_nxt[AW], rd_ptr_nxt[AW-1:0]});
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk_buf_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/o_ddr_lane_burst_tx.sv
// Multi-lane DDR burst transmitter with pad drivers.
// Accepts 2*LANES-bit words on valid/ready, queues them, and sends each burst
// as preamble, payload, postamble through one O_DDR + O_BUFT per lane. Idle
// pads are released to the weak pull-up.
// Ports:
//   clk_buf_i    in   clock (already buffered)
//   reset_n_buf  in   asynchronous active-low reset
//   enable       in   global enable; low freezes FSM, FIFO pop and O_DDR
//   in_valid     in   input word valid
//   in_ready     out  FIFO can accept a word
//   in_data      in   lane l uses bits [2l+1:2l]; bit 2l goes out in clk-high half
//   data_o       out  pads; one extra parity pad when O_DDR_PARITY_LANE_EN is defined
//   tx_active    out  registered, FSM not IDLE
//   tx_count     out  payload words sent since reset, wraps
// Build option: define O_DDR_PARITY_LANE_EN to add an even-parity lane per
// DDR phase at index LANES.
module o_ddr_lane_burst_tx
  import o_ddr_tx_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DEPTH      = 4,
  parameter int PRE_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic               clk_buf_i,
  input  logic               reset_n_buf,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*LANES-1:0] in_data,
`ifdef O_DDR_PARITY_LANE_EN
  output logic [LANES:0]     data_o,
`else
  output logic [LANES-1:0]   data_o,
`endif
  output logic               tx_active,
  output logic [CNT_W-1:0]   tx_count
);

`ifdef O_DDR_PARITY_LANE_EN
  localparam int NPADS = LANES + 1;
`else
  localparam int NPADS = LANES;
`endif

  tx_state_t          state, state_nxt;
  logic [3:0]         pre_cnt, pre_cnt_nxt;
  logic               ready_q, oe_q;
  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [2*LANES-1:0] fifo_rd_data;
  logic [2*LANES-1:0] ddr_d;
  logic [2*NPADS-1:0] pad_d;

  // ready_q keeps in_ready low until the first clock after reset release.
  assign in_ready = ready_q && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = enable && (state == BURST) && !fifo_empty;

  o_ddr_tx_fifo #(
    .WIDTH (2*LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_buf_i   (clk_buf_i),
    .reset_n_buf (reset_n_buf),
    .push        (push),
    .wr_data     (in_data),
    .pop         (pop),
    .rd_data     (fifo_rd_data),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    ddr_d       = {LANES{IDLE_SYM}};
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt   = PRE;
          pre_cnt_nxt = 4'(PRE_CYCLES - 1);
        end
      end
      PRE: begin
        ddr_d = {LANES{PREAMBLE_SYM}};
        if (pre_cnt == 4'd0) state_nxt = BURST;
        else                 pre_cnt_nxt = pre_cnt - 4'd1;
      end
      BURST: begin
        // The empty flag is pre-edge, so a word pushed this cycle waits for
        // the next burst.
        if (!fifo_empty) ddr_d = fifo_rd_data;
        else             state_nxt = POST;
      end
      POST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // oe_q trails the FSM by one flop to line up with the O_DDR register, so
  // the pad is driven exactly while PRE..POST symbols are on the O_DDR output.
  always_ff @(posedge clk_buf_i or negedge reset_n_buf) begin
    if (!reset_n_buf) begin
      state     <= IDLE;
      pre_cnt   <= 4'd0;
      ready_q   <= 1'b0;
      oe_q      <= 1'b0;
      tx_active <= 1'b0;
      tx_count  <= '0;
    end else begin
      ready_q <= 1'b1;
      if (enable) begin
        state     <= state_nxt;
        pre_cnt   <= pre_cnt_nxt;
        oe_q      <= (state != IDLE);
        tx_active <= (state_nxt != IDLE);
        if (pop) tx_count <= tx_count + CNT_W'(1);
      end
    end
  end

`ifdef O_DDR_PARITY_LANE_EN
  logic [1:0] par_d;

  always_comb begin
    par_d = 2'b00;
    for (int l = 0; l < LANES; l++) par_d = par_d ^ ddr_d[2*l +: 2];
  end

  assign pad_d = {par_d, ddr_d};
`else
  assign pad_d = ddr_d;
`endif

  for (genvar l = 0; l < NPADS; l++) begin : g_pad
    logic ddr_q;

    O_DDR u_ddr (
      .D (pad_d[2*l +: 2]),
      .R (!reset_n_buf),
      .E (enable),
      .C (clk_buf_i),
      .Q (ddr_q)
    );

    O_BUFT #(
      .WEAK_KEEPER ("PULLUP")
    ) u_buft (
      .I (ddr_q),
      .T (oe_q),
      .O (data_o[l])
    );
  end

endmodule
